// File: rtl/axi_enhanced_rx_route_ctrl_if.sv
// rtl/axi_enhanced_rx_route_ctrl_if.sv - upstream RX stream plus four-way egress valid/ready bundle
// master drives the upstream stream and egress readies; slave is the route controller.
interface axi_enhanced_rx_route_ctrl_if #(
  parameter int C_DATA_WIDTH = 64
);
  logic [C_DATA_WIDTH-1:0] s_axis_rx_tdata;
  logic                    s_axis_rx_tvalid;
  logic                    s_axis_rx_tready;
  logic                    s_axis_rx_tlast;
  logic [3:0]              dst_tvalid;
  logic [3:0]              dst_tready;

  modport master (
    output s_axis_rx_tdata, s_axis_rx_tvalid, s_axis_rx_tlast, dst_tready,
    input  s_axis_rx_tready, dst_tvalid
  );

  modport slave (
    input  s_axis_rx_tdata, s_axis_rx_tvalid, s_axis_rx_tlast, dst_tready,
    output s_axis_rx_tready, dst_tvalid
  );
endinterface

// File: rtl/axi_enhanced_rx_route_ctrl.sv
// rtl/axi_enhanced_rx_route_ctrl.sv - packet steering to CR/CW/RC/CFG with drop and stall detection
// The route is locked from the header beat and held until the tlast beat is accepted.
module axi_enhanced_rx_route_ctrl #(
  parameter int    C_DATA_WIDTH  = 64,
  parameter string C_ROOT_PORT   = "FALSE",
  parameter int    C_STALL_LIMIT = 1024,
  parameter int    C_CNT_WIDTH   = 16,
  parameter int    TCQ           = 1
) (
  input  logic                         com_iclk,
  input  logic                         com_sysrst,
  axi_enhanced_rx_route_ctrl_if.slave  rx,
  input  logic                         is_msi_trn,
  input  logic                         cfg_req,
  input  logic                         trn_lnk_up,
  output logic [3:0]                   route_sel,
  output logic                         busy,
  output logic [C_CNT_WIDTH-1:0]       drop_cnt,
  output logic                         stall_err
);

  localparam bit ROOT_PORT = (C_ROOT_PORT == "TRUE") ? 1'b1 : 1'b0;
  localparam int SW = $clog2(C_STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_LIMIT = SW'(C_STALL_LIMIT);
  localparam logic [3:0] R_CR  = 4'b0001;
  localparam logic [3:0] R_CW  = 4'b0010;
  localparam logic [3:0] R_RC  = 4'b0100;
  localparam logic [3:0] R_CFG = 4'b1000;
  localparam int unused_tcq = TCQ;

  typedef enum logic [1:0] {S_IDLE, S_ROUTE, S_DROP} state_t;

  state_t                 state_q;
  logic [3:0]             route_sel_q;
  logic                   busy_q;
  logic [C_CNT_WIDTH-1:0] drop_cnt_q;
  logic [SW-1:0]          stall_cnt_q, stall_cnt_d;
  logic                   stall_err_q, stall_err_d;

  logic [6:0] ft;
  logic [3:0] dec_route;
  logic       tready;
  logic       accepted;
  logic       last_accepted;
  logic       unused_tdata;

  assign ft            = rx.s_axis_rx_tdata[30:24];
  assign unused_tdata  = ^rx.s_axis_rx_tdata;

  // Ready depends only on registered state and egress readies, never on tvalid.
  assign tready        = (state_q == S_DROP) | (|(route_sel_q & rx.dst_tready));
  assign accepted      = rx.s_axis_rx_tvalid & tready;
  assign last_accepted = accepted & rx.s_axis_rx_tlast;

  assign rx.s_axis_rx_tready = tready;
  assign rx.dst_tvalid       = route_sel_q & {4{rx.s_axis_rx_tvalid}};
  assign route_sel           = route_sel_q;
  assign busy                = busy_q;
  assign drop_cnt            = drop_cnt_q;
  assign stall_err           = stall_err_q;

  // A zero result means the packet is dropped.
  always_comb begin
    dec_route = 4'b0000;
    if (!trn_lnk_up) begin
      dec_route = 4'b0000;
    end else if (ft[6] && ft[4:0] == 5'b00000 && ROOT_PORT && is_msi_trn) begin
      dec_route = R_CFG;
    end else if (!ft[6] && (ft[4:0] == 5'b00000 || ft[4:0] == 5'b00001 || ft[4:0] == 5'b00010)) begin
      dec_route = R_CR;
    end else if (ft[6] && (ft[4:0] == 5'b00000 || ft[4:0] == 5'b00010)) begin
      dec_route = R_CW;
    end else if (ft[4:0] == 5'b01010 || ft[4:0] == 5'b01011) begin
      dec_route = cfg_req ? R_CFG : R_RC;
    end else if (ft[4:3] == 2'b10) begin
      dec_route = R_CFG;
    end
  end

  always_ff @(posedge com_iclk) begin
    if (com_sysrst) begin
      state_q     <= S_IDLE;
      route_sel_q <= 4'b0000;
      busy_q      <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx.s_axis_rx_tvalid) begin
            busy_q <= 1'b1;
            if (dec_route == 4'b0000) begin
              state_q <= S_DROP;
              if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            end else begin
              state_q     <= S_ROUTE;
              route_sel_q <= dec_route;
            end
          end
        end
        S_ROUTE, S_DROP: begin
          if (last_accepted) begin
            state_q     <= S_IDLE;
            route_sel_q <= 4'b0000;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          route_sel_q <= 4'b0000;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Counter saturates at the limit so the error fires once per stall episode.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q != S_ROUTE || accepted) begin
      stall_cnt_d = '0;
    end else if (rx.s_axis_rx_tvalid && stall_cnt_q != STALL_LIMIT) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    stall_err_d = (stall_cnt_d == STALL_LIMIT) && (stall_cnt_q != STALL_LIMIT);
  end

  always_ff @(posedge com_iclk) begin
    if (com_sysrst) begin
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

endmodule
